gpio_unit: RTL and testbench
============================

GPIO_UNIT -- requirements
Module: gpio_unit

Interface
REQ-001 SHALL have parameter NGPIO, default 9: number of output channels.
REQ-002 SHALL have parameters CMD_SET_DIGITAL_OUT=15, CMD_CONFIG_DIGITAL_OUT=16, CMD_SCHEDULE_DIGITAL_OUT=17 and CMD_UPDATE_DIGITAL_OUT=18, default as given: the command IDs.
REQ-003 SHALL use one clock and a synchronous, active-high reset; ports clk (in, 1) and rst (in, 1).
REQ-004 SHALL have port systime, in, 64 bits: global time; only bits [31:0] are used.
REQ-005 SHALL have ports arg_data (in, 32), the current argument, and arg_advance (out, 1), a request for the next argument.
REQ-006 SHALL have ports cmd (in, 5), the command ID; cmd_ready (in, 1), a 1-cycle start pulse; and cmd_done (out, 1), a 1-cycle completion pulse.
REQ-007 SHALL have ports param_data (out, 32) and param_write (out, 1), tied to 0; no responses are produced.
REQ-008 SHALL have ports invol_req (out, 1), tied 0, and invol_grant (in, 1), ignored.
REQ-009 SHALL have ports gpio (out, NGPIO), the registered outputs, and shutdown (in, 1), a level.
REQ-010 SHALL have port missed_clock (out, 1): sticky late-schedule flag.

Function
REQ-011 SHALL capture args[0] while cmd_ready is high.
REQ-012 SHALL obtain each further argument by pulsing arg_advance for 1 cycle, then sampling arg_data in the following cycle.
REQ-013 SHALL consume exactly the argument count of each command: SET=2 (ch,val); CONFIG=4 (ch,val,default,max_dur); SCHEDULE=3 (ch,clock,val); UPDATE=2 (ch,val).
REQ-014 SHALL use val bit 0 as the output value.
REQ-015 SHALL pulse cmd_done once after the last argument is sampled; gpio changes on the same edge cmd_done rises.
REQ-016 SHALL, for an unknown cmd, pulse cmd_done in the cycle after cmd_ready and request no arguments.
REQ-017 SHALL, when ch >= NGPIO, consume all arguments and pulse cmd_done with no state change.
REQ-018 CONFIG SHALL set gpio[ch]=val, store default[ch] and max_dur[ch], and clear the channel's pending schedule.
REQ-019 SET and UPDATE SHALL set gpio[ch]=val immediately; UPDATE also clears the channel's pending schedule.
REQ-020 SCHEDULE SHALL store one pending entry per channel (time, value); a new SCHEDULE overwrites the old entry.
REQ-021 A pending entry SHALL fire when the signed 32-bit value (systime[31:0] - time) >= 0; firing writes gpio[ch] and clears the entry.
REQ-022 SHALL, if (clock - systime[31:0]) is signed-negative at the moment the SCHEDULE is accepted, set missed_clock; the entry still fires on the next cycle.
REQ-023 missed_clock SHALL stay high until rst.
REQ-024 SHALL apply a command write and a schedule fire on the same channel in the same cycle with the command write taking precedence.
REQ-025 Command state machine SHALL have the states IDLE, ARG (sample), ADV (advance), WAIT and DONE; it returns to IDLE after DONE and never blocks for more than 2 cycles per argument.
REQ-026 While shutdown is high: gpio SHALL equal default per channel, all pending entries SHALL be cleared, and commands SHALL still be acknowledged without output effect.

Reset
REQ-027 rst SHALL clear gpio, all defaults, max_dur, pending entries, watchdog counters, missed_clock, cmd_done and arg_advance to 0, and return the state machine to IDLE.
REQ-028 rst asserted mid-command SHALL abort the command with no cmd_done.

Configuration
REQ-029 Macro GPIO_MAX_DURATION_EN defined: each channel SHALL have a 32-bit watchdog, loaded with max_dur[ch] whenever gpio[ch] is written to a value != default[ch].
REQ-030 With GPIO_MAX_DURATION_EN defined, the watchdog SHALL decrement each cycle and, on reaching 0, force gpio[ch]=default[ch]; max_dur=0 disables the watchdog.
REQ-031 Macro GPIO_MAX_DURATION_EN undefined: max_dur SHALL be consumed and ignored, and no watchdog logic SHALL be present.

Verification
REQ-032 CONFIG(ch=2, val=1, def=0, max=0) -> gpio[2]=1 on the cmd_done edge; exactly 3 arg_advance pulses.
REQ-033 SET(ch=0, 1) then SET(ch=0, 0) -> gpio[0] rises, then falls; each command produces 1 cmd_done.
REQ-034 systime=1000, SCHEDULE(ch=1, 1050, 1) -> gpio[1] goes high in the cycle after systime[31:0] reaches 1050; missed_clock=0.
REQ-035 systime=2000, SCHEDULE(ch=1, 1990, 1) -> missed_clock=1 and gpio[1]=1 one cycle later; missed_clock stays 1 until rst.
REQ-036 CONFIG(ch=3, val=0, def=1) then SET(ch=3, 0), then shutdown=1 -> gpio[3]=1, and later commands leave gpio unchanged.
REQ-037 With GPIO_MAX_DURATION_EN: CONFIG(ch=4, val=1, def=0, max=10) -> gpio[4] returns to 0 after 10 cycles unless refreshed by SET.

Source files
------------

// File: rtl/gpio_unit_if.sv
// Command/argument handshake between the command dispatcher (master) and gpio_unit (slave).
interface gpio_unit_if;
   logic [31:0] arg_data;
   logic        arg_advance;
   logic [4:0]  cmd;
   logic        cmd_ready;
   logic        cmd_done;
   logic [31:0] param_data;
   logic        param_write;
   logic        invol_req;
   logic        invol_grant;

   modport master (
      output arg_data, cmd, cmd_ready, invol_grant,
      input  arg_advance, cmd_done, param_data, param_write, invol_req
   );

   modport slave (
      input  arg_data, cmd, cmd_ready, invol_grant,
      output arg_advance, cmd_done, param_data, param_write, invol_req
   );
endinterface

// File: rtl/gpio_unit.sv
// Command-driven digital outputs with one pending timed write per channel.
// Define GPIO_MAX_DURATION_EN to add a per-channel max-duration watchdog.
module gpio_unit #(
   parameter int unsigned NGPIO                    = 9,
   parameter int unsigned CMD_SET_DIGITAL_OUT      = 15,
   parameter int unsigned CMD_CONFIG_DIGITAL_OUT   = 16,
   parameter int unsigned CMD_SCHEDULE_DIGITAL_OUT = 17,
   parameter int unsigned CMD_UPDATE_DIGITAL_OUT   = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [63:0]      systime,
   gpio_unit_if.slave       bus,
   output logic [NGPIO-1:0] gpio,
   input  logic             shutdown,
   output logic             missed_clock
);
   typedef enum logic [2:0] {StIdle, StArg, StAdv, StWait, StDone} state_t;

   state_t           r_state;
   logic [4:0]       r_cmd;
   logic [1:0]       r_idx;
   logic [2:0]       r_nargs;
   logic [31:0]      r_args [4];
   logic             r_arg_advance;
   logic             r_cmd_done;
   logic [NGPIO-1:0] r_gpio, r_default, r_pend_v, r_pend_val;
   logic [31:0]      r_pend_t [NGPIO];
   logic             r_missed;

   logic [2:0]       w_nargs_in;
   logic             w_is_set, w_is_cfg, w_is_sched, w_is_upd, w_is_write;
   logic             w_act, w_late;
   logic [31:0]      w_lead;
   logic [31:0]      w_age [NGPIO];
   logic [NGPIO-1:0] w_sel, w_fire, w_wr, w_wr_val, w_def_next, w_expire;
   logic             w_unused;

   always_comb begin
      w_nargs_in = 3'd0;
      if ({27'd0, bus.cmd} == CMD_SET_DIGITAL_OUT)      w_nargs_in = 3'd2;
      if ({27'd0, bus.cmd} == CMD_CONFIG_DIGITAL_OUT)   w_nargs_in = 3'd4;
      if ({27'd0, bus.cmd} == CMD_SCHEDULE_DIGITAL_OUT) w_nargs_in = 3'd3;
      if ({27'd0, bus.cmd} == CMD_UPDATE_DIGITAL_OUT)   w_nargs_in = 3'd2;
   end

   // Each further argument costs an advance cycle followed by a sample cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= StIdle;
         r_cmd         <= '0;
         r_idx         <= '0;
         r_nargs       <= '0;
         r_arg_advance <= 1'b0;
         r_cmd_done    <= 1'b0;
         for (int i = 0; i < 4; i++) r_args[i] <= '0;
      end else begin
         r_arg_advance <= 1'b0;
         r_cmd_done    <= 1'b0;
         unique case (r_state)
            StIdle, StDone: begin
               r_state <= StIdle;
               if (bus.cmd_ready) begin
                  r_cmd     <= bus.cmd;
                  r_args[0] <= bus.arg_data;
                  r_idx     <= 2'd1;
                  r_nargs   <= w_nargs_in;
                  if (w_nargs_in == 3'd0) begin
                     r_cmd_done <= 1'b1;
                     r_state    <= StDone;
                  end else begin
                     r_arg_advance <= 1'b1;
                     r_state       <= StAdv;
                  end
               end
            end
            StAdv: r_state <= StArg;
            StArg: begin
               r_args[r_idx] <= bus.arg_data;
               if ({1'b0, r_idx} + 3'd1 == r_nargs) begin
                  r_state <= StWait;
               end else begin
                  r_idx         <= r_idx + 2'd1;
                  r_arg_advance <= 1'b1;
                  r_state       <= StAdv;
               end
            end
            StWait: begin
               r_cmd_done <= 1'b1;
               r_state    <= StDone;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign w_is_set   = ({27'd0, r_cmd} == CMD_SET_DIGITAL_OUT);
   assign w_is_cfg   = ({27'd0, r_cmd} == CMD_CONFIG_DIGITAL_OUT);
   assign w_is_sched = ({27'd0, r_cmd} == CMD_SCHEDULE_DIGITAL_OUT);
   assign w_is_upd   = ({27'd0, r_cmd} == CMD_UPDATE_DIGITAL_OUT);
   assign w_is_write = w_is_set | w_is_cfg | w_is_upd;
   assign w_act      = (r_state == StWait) && (r_args[0] < NGPIO) && !shutdown;
   assign w_lead     = r_args[1] - systime[31:0];
   assign w_late     = w_act && w_is_sched && w_lead[31];

   // Command writes take precedence over a schedule firing on the same channel.
   always_comb begin
      for (int i = 0; i < int'(NGPIO); i++) begin
         w_sel[i]      = w_act && (r_args[0] == 32'(i));
         w_age[i]      = systime[31:0] - r_pend_t[i];
         w_fire[i]     = r_pend_v[i] && !w_age[i][31];
         w_wr[i]       = (w_sel[i] && w_is_write) || w_fire[i];
         w_wr_val[i]   = (w_sel[i] && w_is_write) ? r_args[1][0] : r_pend_val[i];
         w_def_next[i] = (w_sel[i] && w_is_cfg) ? r_args[2][0] : r_default[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gpio     <= '0;
         r_default  <= '0;
         r_pend_v   <= '0;
         r_pend_val <= '0;
         r_missed   <= 1'b0;
         for (int i = 0; i < int'(NGPIO); i++) r_pend_t[i] <= '0;
      end else begin
         if (w_late) r_missed <= 1'b1;
         r_default <= w_def_next;
         for (int i = 0; i < int'(NGPIO); i++) begin
            if (shutdown) begin
               r_gpio[i]   <= r_default[i];
               r_pend_v[i] <= 1'b0;
            end else begin
               if (w_wr[i])          r_gpio[i] <= w_wr_val[i];
               else if (w_expire[i]) r_gpio[i] <= r_default[i];
               if (w_sel[i] && w_is_sched) begin
                  r_pend_v[i]   <= 1'b1;
                  r_pend_t[i]   <= r_args[1];
                  r_pend_val[i] <= r_args[2][0];
               end else if (w_fire[i] || (w_sel[i] && (w_is_cfg || w_is_upd))) begin
                  r_pend_v[i] <= 1'b0;
               end
            end
         end
      end
   end

`ifdef GPIO_MAX_DURATION_EN
   logic [31:0] r_max_dur [NGPIO];
   logic [31:0] r_wdog    [NGPIO];

   // Counter reaching 1 means this edge is the last cycle away from default.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NGPIO); i++) begin
            r_max_dur[i] <= '0;
            r_wdog[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NGPIO); i++) begin
            if (w_sel[i] && w_is_cfg) r_max_dur[i] <= r_args[3];
            if (shutdown) begin
               r_wdog[i] <= '0;
            end else if (w_wr[i]) begin
               if (w_wr_val[i] == w_def_next[i]) r_wdog[i] <= '0;
               else r_wdog[i] <= (w_sel[i] && w_is_cfg) ? r_args[3] : r_max_dur[i];
            end else if (r_wdog[i] != 32'd0) begin
               r_wdog[i] <= r_wdog[i] - 32'd1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NGPIO); i++) w_expire[i] = (r_wdog[i] == 32'd1);
   end

   assign w_unused = ^{systime[63:32], bus.invol_grant, r_args[2][31:1]};
`else
   assign w_expire = '0;
   assign w_unused = ^{systime[63:32], bus.invol_grant, r_args[2][31:1], r_args[3]};
`endif

   assign bus.arg_advance = r_arg_advance;
   assign bus.cmd_done    = r_cmd_done;
   assign bus.param_data  = '0;
   assign bus.param_write = 1'b0;
   assign bus.invol_req   = 1'b0;
   assign gpio            = r_gpio;
   assign missed_clock    = r_missed;
endmodule

// File: tb/tb_gpio_unit.sv
// Directed and randomized bench for gpio_unit against a behavioural channel model.
// Watchdog checks are compiled in only when GPIO_MAX_DURATION_EN is defined.
module tb_gpio_unit;
   localparam int N = 9;
   localparam logic [4:0] C_SET = 5'd15;
   localparam logic [4:0] C_CFG = 5'd16;
   localparam logic [4:0] C_SCH = 5'd17;
   localparam logic [4:0] C_UPD = 5'd18;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          shutdown = 1'b0;
   logic [63:0]   systime = 64'd0;
   logic [N-1:0]  gpio;
   logic          missed_clock;

   gpio_unit_if bus ();

   gpio_unit #(.NGPIO(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .systime      (systime),
      .bus          (bus),
      .gpio         (gpio),
      .shutdown     (shutdown),
      .missed_clock (missed_clock)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;
   int last_adv;

   // Behavioural model: output level, default, max duration, remaining on-time, pending entry.
   logic [N-1:0] m_gpio, m_def, m_pv, m_pval;
   logic [31:0]  m_pt [N];
   logic [31:0]  m_max [N];
   logic [31:0]  m_wd [N];
   logic         m_missed;
   logic [31:0]  m_s;
   logic         m_sd;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_gpio = '0; m_def = '0; m_pv = '0; m_pval = '0; m_missed = 1'b0;
      for (int c = 0; c < N; c++) begin
         m_pt[c] = '0; m_max[c] = '0; m_wd[c] = '0;
      end
   endfunction

   function automatic void m_write(input int c, input logic v);
      m_gpio[c] = v;
      m_wd[c]   = (v != m_def[c]) ? m_max[c] : 32'd0;
   endfunction

   // One clock of time passing with systime s and shutdown level sd.
   function automatic void model_step(input logic [31:0] s, input logic sd);
      if (sd) begin
         m_gpio = m_def;
         m_pv   = '0;
         for (int c = 0; c < N; c++) m_wd[c] = '0;
         return;
      end
      for (int c = 0; c < N; c++) begin
         if (m_wd[c] != 0) begin
            m_wd[c] = m_wd[c] - 1;
            if (m_wd[c] == 0) m_gpio[c] = m_def[c];
         end
      end
      for (int c = 0; c < N; c++) begin
         if (m_pv[c] && int'(s - m_pt[c]) >= 0) begin
            m_write(c, m_pval[c]);
            m_pv[c] = 1'b0;
         end
      end
   endfunction

   function automatic void model_cmd(input logic [4:0] c, input logic [31:0] a0, a1, a2, a3);
      int ch;
      if (m_sd || a0 >= 32'(N)) return;
      ch = int'(a0);
      if (c == C_SET) m_write(ch, a1[0]);
      if (c == C_UPD) begin
         m_pv[ch] = 1'b0;
         m_write(ch, a1[0]);
      end
      if (c == C_CFG) begin
         m_def[ch] = a2[0];
`ifdef GPIO_MAX_DURATION_EN
         m_max[ch] = a3;
`else
         m_max[ch] = 32'd0;
`endif
         m_pv[ch] = 1'b0;
         m_write(ch, a1[0]);
      end
      if (c == C_SCH) begin
         m_pv[ch]   = 1'b1;
         m_pt[ch]   = a1;
         m_pval[ch] = a2[0];
         if (int'(a1 - m_s) < 0) m_missed = 1'b1;
      end
   endfunction

   task automatic tick();
      logic [31:0] s;
      logic        sd, r;
      s = systime[31:0]; sd = shutdown; r = rst;
      @(posedge clk);
      #1;
      m_s = s; m_sd = sd;
      if (r) model_reset();
      else model_step(s, sd);
      systime = systime + 64'd1;
   endtask

   task automatic idle(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         tick();
         check(tag, gpio, m_gpio);
      end
   endtask

   task automatic do_cmd(input string tag, input logic [4:0] c,
                         input logic [31:0] a0, a1, a2, a3, input int nargs);
      logic [31:0] a [4];
      int adv, cyc;
      bit done;
      a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
      adv = 0; cyc = 0; done = 1'b0;
      bus.cmd = c; bus.arg_data = a0; bus.cmd_ready = 1'b1;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
         bus.cmd_ready = 1'b0;
         if (bus.arg_advance === 1'b1) begin
            adv++;
            if (adv < 4) bus.arg_data = a[adv];
         end
         if (bus.cmd_done === 1'b1) begin
            done = 1'b1;
            model_cmd(c, a0, a1, a2, a3);
         end
         check({tag, " gpio"}, gpio, m_gpio);
      end
      check({tag, " done seen"}, done, 1);
      check({tag, " advances"}, adv, (nargs == 0) ? 0 : nargs - 1);
      if (nargs == 0) check({tag, " unknown latency"}, cyc, 1);
      check({tag, " missed"}, missed_clock, m_missed);
      last_adv = adv;
      tick();
      check({tag, " done single"}, bus.cmd_done, 0);
      check({tag, " gpio after"}, gpio, m_gpio);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      bus.cmd = '0; bus.cmd_ready = 1'b0; bus.arg_data = '0; bus.invol_grant = 1'b0;
      model_reset();
      systime = {32'($urandom), 32'd100};
      do_reset();

      check("rst gpio", gpio, 0);
      check("rst missed", missed_clock, 0);
      check("rst cmd_done", bus.cmd_done, 0);
      check("rst arg_advance", bus.arg_advance, 0);
      check("param_write", bus.param_write, 0);
      check("param_data", bus.param_data, 0);
      check("invol_req", bus.invol_req, 0);

      do_cmd("cfg2", C_CFG, 32'd2, 32'd1, 32'd0, 32'd0, 4);
      check("cfg2 gpio2", gpio[2], 1);
      check("cfg2 adv count", last_adv, 3);

      do_cmd("set0 hi", C_SET, 32'd0, 32'd1, 32'd0, 32'd0, 2);
      check("set0 rise", gpio[0], 1);
      do_cmd("set0 lo", C_SET, 32'd0, 32'd2, 32'd0, 32'd0, 2);
      check("set0 fall", gpio[0], 0);

      do_cmd("unknown", 5'd3, 32'd1, 32'd0, 32'd0, 32'd0, 0);
      do_cmd("oor set", C_SET, 32'(N), 32'd1, 32'd0, 32'd0, 2);
      do_cmd("oor sched", C_SCH, 32'(N + 1), 32'd0, 32'd1, 32'd0, 3);

      systime[31:0] = 32'd1000;
      do_cmd("sched1", C_SCH, 32'd1, 32'd1050, 32'd1, 32'd0, 3);
      check("sched1 missed", missed_clock, 0);
      for (int k = 0; k < 60; k++) begin
         logic [31:0] sp;
         sp = systime[31:0];
         tick();
         check("sched1 model", gpio, m_gpio);
         if (sp == 32'd1049 || sp == 32'd1050) check("sched1 edge", gpio[1], sp == 32'd1050);
      end

      for (int it = 0; it < 60; it++) begin
         int          kind;
         logic [31:0] ch, v, t;
         kind = int'($urandom_range(0, 5));
         ch = 32'($urandom_range(0, N + 1));
         v = $urandom;
         shutdown = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) systime = systime + 64'($urandom_range(0, 40));
         t = systime[31:0] + 32'($urandom_range(0, 60)) - 32'd20;
         case (kind)
            0:       do_cmd("rnd set", C_SET, ch, v, 32'd0, 32'd0, 2);
            1:       do_cmd("rnd upd", C_UPD, ch, v, 32'd0, 32'd0, 2);
            2:       do_cmd("rnd cfg", C_CFG, ch, v, $urandom, 32'($urandom_range(0, 12)), 4);
            5:       do_cmd("rnd unk", 5'($urandom_range(19, 31)), ch, 32'd0, 32'd0, 32'd0, 0);
            default: do_cmd("rnd sch", C_SCH, ch, t, v, 32'd0, 3);
         endcase
         idle(int'($urandom_range(0, 4)), "rnd idle");
      end
      shutdown = 1'b0;
      idle(3, "rnd tail");

      do_reset();
      check("rst2 missed", missed_clock, 0);
      check("rst2 gpio", gpio, 0);
      systime[31:0] = 32'd2000;
      do_cmd("late", C_SCH, 32'd1, 32'd1990, 32'd1, 32'd0, 3);
      check("late gpio1", gpio[1], 1);
      idle(5, "late idle");
      do_cmd("late set", C_SET, 32'd1, 32'd0, 32'd0, 32'd0, 2);
      check("late sticky", missed_clock, 1);

      do_cmd("cfg3", C_CFG, 32'd3, 32'd0, 32'd1, 32'd0, 4);
      do_cmd("set3", C_SET, 32'd3, 32'd0, 32'd0, 32'd0, 2);
      check("set3 low", gpio[3], 0);
      shutdown = 1'b1;
      tick();
      check("shutdown gpio3", gpio[3], 1);
      do_cmd("sd set", C_SET, 32'd3, 32'd0, 32'd0, 32'd0, 2);
      do_cmd("sd sch", C_SCH, 32'd3, systime[31:0], 32'd0, 32'd0, 3);
      do_cmd("sd upd", C_UPD, 32'd0, 32'd1, 32'd0, 32'd0, 2);
      check("sd gpio3 held", gpio[3], 1);
      check("sd gpio0 held", gpio[0], 0);
      shutdown = 1'b0;
      idle(2, "sd release");

`ifdef GPIO_MAX_DURATION_EN
      do_cmd("wd cfg", C_CFG, 32'd4, 32'd1, 32'd0, 32'd10, 4);
      for (int k = 2; k < 12; k++) begin
         tick();
         check("wd expire", gpio[4], k < 10);
      end
      do_cmd("wd cfg2", C_CFG, 32'd4, 32'd1, 32'd0, 32'd10, 4);
      do_cmd("wd refresh", C_SET, 32'd4, 32'd1, 32'd0, 32'd0, 2);
      for (int k = 2; k < 12; k++) begin
         tick();
         check("wd refreshed", gpio[4], k < 10);
      end
`endif

      bus.cmd = C_CFG; bus.arg_data = 32'd5; bus.cmd_ready = 1'b1;
      tick();
      bus.cmd_ready = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("abort no done", bus.cmd_done, 0);
         check("abort no adv", bus.arg_advance, 0);
      end
      check("abort gpio", gpio, 0);
      check("abort missed", missed_clock, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
